// File: rtl/lfsr_bank_lookahead.sv
// Bank of CH Fibonacci XNOR LFSRs with an N-step lookahead per accepted word,
// a valid/ready output stream, per-channel reseeding and lock-up recovery.
module lfsr_bank_lookahead #(
    parameter int unsigned       LENGTH = 16,
    parameter int unsigned       N      = 4,
    parameter int unsigned       CH     = 4,
    parameter logic [LENGTH-1:0] TAPS   = 16'b1011010000000000,
    parameter logic [LENGTH-1:0] SEED   = 16'hcafe,
    parameter int unsigned       CW     = 32,
    localparam int unsigned      SW     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH*N-1:0]   out_data,
    input  logic              seed_valid,
    input  logic [SW-1:0]     seed_ch,
    input  logic [LENGTH-1:0] seed_data,
    output logic              lock_err,
    output logic [CW-1:0]     word_cnt
);

    localparam logic [LENGTH-1:0] SEED_STRIDE = LENGTH'(16'h9E37);
    localparam logic [LENGTH-1:0] ALL_ONES    = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    fsm_t                         fsm;
    logic                         accept;
    logic                         lock_hit;
    logic [CH-1:0][LENGTH-1:0]    lfsr_q;
    logic [CH-1:0][LENGTH-1:0]    lfsr_d;

    // One XNOR Fibonacci step: feedback enters at the LSB.
    function automatic logic [LENGTH-1:0] step1(input logic [LENGTH-1:0] s);
        return {s[LENGTH-2:0], ~^(s & TAPS)};
    endfunction

    // N chained single steps, flattened into one cycle of logic.
    function automatic logic [LENGTH-1:0] stepn(input logic [LENGTH-1:0] s);
        logic [LENGTH-1:0] t;
        t = s;
        for (int unsigned i = 0; i < N; i++) begin
            t = step1(t);
        end
        return t;
    endfunction

    // Per-channel default seed; never returns the XNOR lock-up state.
    function automatic logic [LENGTH-1:0] dseed(input int unsigned c);
        logic [LENGTH-1:0] d;
        d = SEED ^ (LENGTH'(c) * SEED_STRIDE);
        return (d == ALL_ONES) ? SEED : d;
    endfunction

    assign accept = out_valid & out_ready;

    // Next state per channel: seed load beats lock-up recovery beats advance.
    always_comb begin
        lfsr_d   = lfsr_q;
        lock_hit = 1'b0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (seed_valid && (seed_ch == SW'(c))) begin
                if (seed_data == ALL_ONES) begin
                    lfsr_d[c] = dseed(c);
                    lock_hit  = 1'b1;
                end else begin
                    lfsr_d[c] = seed_data;
                end
            end else if (lfsr_q[c] == ALL_ONES) begin
                lfsr_d[c] = dseed(c);
                lock_hit  = 1'b1;
            end else if (accept) begin
                lfsr_d[c] = stepn(lfsr_q[c]);
            end
        end
    end

    // Stream control: out_valid follows en one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (en) begin
                        fsm       <= RUN;
                        out_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // LFSR states, sticky lock flag and accepted-word counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned c = 0; c < CH; c++) begin
                lfsr_q[c] <= dseed(c);
            end
            lock_err <= 1'b0;
            word_cnt <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            if (lock_hit) begin
                lock_err <= 1'b1;
            end
            if (accept) begin
                word_cnt <= word_cnt + CW'(1);
            end
        end
    end

    // Each lane exposes the top N bits of its current state.
    for (genvar c = 0; c < CH; c++) begin : g_out
        assign out_data[c*N +: N] = lfsr_q[c][LENGTH-1 -: N];
    end

endmodule

// File: tb/tb_lfsr_bank_lookahead.sv
// Bench for lfsr_bank_lookahead: a 4x4 instance and a 1x1 instance sharing
// stream controls, checked against a bit-stream model of each lane.
module tb_lfsr_bank_lookahead;

    localparam int NL   = 5;      // lanes 0..3: big instance, lane 4: small one
    localparam int MAXB = 8192;
    localparam logic [15:0] TAPS = 16'b1011010000000000;

    logic        clk;
    logic        rst;
    logic        en;
    logic        out_ready;
    logic        seed_valid;
    logic [1:0]  seed_ch;
    logic [15:0] seed_data;
    logic        sv1;
    logic [0:0]  sch1;

    logic        v4, v1;
    logic [15:0] d4;
    logic [0:0]  d1;
    logic        lock4, lock1;
    logic [31:0] wc4, wc1;

    lfsr_bank_lookahead u_dut (
        .clk(clk), .rst(rst), .en(en), .out_valid(v4), .out_ready(out_ready),
        .out_data(d4), .seed_valid(seed_valid), .seed_ch(seed_ch),
        .seed_data(seed_data), .lock_err(lock4), .word_cnt(wc4)
    );

    lfsr_bank_lookahead #(.N(1), .CH(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .out_valid(v1), .out_ready(out_ready),
        .out_data(d1), .seed_valid(sv1), .seed_ch(sch1),
        .seed_data(seed_data), .lock_err(lock1), .word_cnt(wc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Lane model: each lane is a bit stream; the current state is the 16-bit
    // window starting at hd, oldest bit first (= state MSB).
    bit          mb [NL][MAXB];
    int          hd [NL];
    int          tl [NL];
    int          nstep [NL];
    bit          m_valid;
    bit          m_lock [2];
    logic [31:0] m_cnt [2];

    function automatic logic [15:0] m_dseed(input int c);
        logic [31:0] p;
        logic [15:0] d;
        p = c * 32'h9E37;
        d = 16'hCAFE ^ p[15:0];
        if (d == 16'hFFFF) d = 16'hCAFE;
        return d;
    endfunction

    function automatic void lane_load(input int l, input logic [15:0] v);
        hd[l] = 0;
        tl[l] = 0;
        for (int i = 15; i >= 0; i--) begin
            mb[l][tl[l]] = v[i];
            tl[l]++;
        end
    endfunction

    // Append the next stream bit: XNOR of the tapped bits of the newest window.
    function automatic void lane_gen(input int l);
        bit b;
        b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (TAPS[i]) b = b ^ mb[l][tl[l]-1-i];
        end
        mb[l][tl[l]] = b;
        tl[l]++;
    endfunction

    function automatic void lane_adv(input int l);
        while (tl[l] - hd[l] < 16 + nstep[l]) lane_gen(l);
        hd[l] += nstep[l];
    endfunction

    function automatic logic [15:0] lane_state(input int l);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[15-i] = mb[l][hd[l]+i];
        return v;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) lane_load(c, m_dseed(c));
        lane_load(4, m_dseed(0));
        m_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_lock[k] = 1'b0;
            m_cnt[k]  = '0;
        end
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    function automatic void model_edge();
        bit acc;
        bit hit;
        int inst;
        int dc;
        acc = m_valid && out_ready;
        for (int l = 0; l < NL; l++) begin
            inst = (l == 4) ? 1 : 0;
            dc   = (l == 4) ? 0 : l;
            hit  = (l == 4) ? (sv1 && sch1 == 1'b0) : (seed_valid && int'(seed_ch) == l);
            if (hit) begin
                if (seed_data == 16'hFFFF) begin
                    lane_load(l, m_dseed(dc));
                    m_lock[inst] = 1'b1;
                end else begin
                    lane_load(l, seed_data);
                end
            end else if (lane_state(l) == 16'hFFFF) begin
                lane_load(l, m_dseed(dc));
                m_lock[inst] = 1'b1;
            end else if (acc) begin
                lane_adv(l);
            end
        end
        if (acc) begin
            m_cnt[0] = m_cnt[0] + 32'd1;
            m_cnt[1] = m_cnt[1] + 32'd1;
        end
        m_valid = en;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [15:0] e;
        logic [15:0] s;
        e = '0;
        for (int c = 0; c < 4; c++) begin
            s = lane_state(c);
            e[c*4 +: 4] = s[15:12];
        end
        s = lane_state(4);
        chk("valid",  v4,    m_valid);
        chk("data",   d4,    e);
        chk("cnt",    wc4,   m_cnt[0]);
        chk("lock",   lock4, m_lock[0]);
        chk("valid1", v1,    m_valid);
        chk("data1",  d1,    s[15]);
        chk("cnt1",   wc1,   m_cnt[1]);
        chk("lock1",  lock1, m_lock[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        bit          en;
        bit          ready;
        bit          sv;
        logic [1:0]  sch;
        logic [15:0] sd;
        bit          ev;
        int          ecnt;
        bit          elock;
    } vec_t;

    function automatic vec_t mk(input bit e, input bit r, input bit s, input logic [1:0] ch,
                                input logic [15:0] sd, input bit ev, input int ec, input bit el);
        vec_t v;
        v.en = e; v.ready = r; v.sv = s; v.sch = ch; v.sd = sd;
        v.ev = ev; v.ecnt = ec; v.elock = el;
        return v;
    endfunction

    vec_t tbl [14];
    logic [3:0][15:0] fv;
    logic [31:0] fcnt;

    initial begin
        for (int l = 0; l < 4; l++) nstep[l] = 4;
        nstep[4] = 1;

        tbl[0]  = mk(0, 0, 0, 2'd0, 16'h0000, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 2'd0, 16'h0000, 1, 0, 0);
        tbl[2]  = mk(1, 1, 0, 2'd0, 16'h0000, 1, 1, 0);
        for (int i = 3; i < 8; i++) tbl[i] = mk(1, 0, 0, 2'd0, 16'h0000, 1, 1, 0);
        tbl[8]  = mk(1, 1, 1, 2'd2, 16'h1234, 1, 2, 0);
        tbl[9]  = mk(1, 0, 0, 2'd0, 16'h0000, 1, 2, 0);
        tbl[10] = mk(0, 0, 0, 2'd0, 16'h0000, 0, 2, 0);
        tbl[11] = mk(0, 1, 0, 2'd0, 16'h0000, 0, 2, 0);
        tbl[12] = mk(1, 1, 1, 2'd0, 16'hFFFF, 1, 2, 1);
        tbl[13] = mk(1, 1, 0, 2'd0, 16'h0000, 1, 3, 1);

        rst = 1'b0; en = 1'b0; out_ready = 1'b0;
        seed_valid = 1'b0; seed_ch = '0; seed_data = '0; sv1 = 1'b0; sch1 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_all();
        chk("rst_data1_const", d1, 1'b1);
        chk("rst_cnt_const", wc4, 0);

        // Directed table: enable latency, first accept, stall, seed, drop.
        for (int i = 0; i < 14; i++) begin
            en = tbl[i].en; out_ready = tbl[i].ready;
            seed_valid = tbl[i].sv; seed_ch = tbl[i].sch; seed_data = tbl[i].sd;
            cycle();
            chk($sformatf("tbl%0d_valid", i), v4, tbl[i].ev);
            chk($sformatf("tbl%0d_cnt", i), wc4, tbl[i].ecnt);
            chk($sformatf("tbl%0d_lock", i), lock4, tbl[i].elock);
            if (i == 2) begin
                chk("first_step_state", u_dut1.lfsr_q[0], 16'h95FC);
                chk("first_step_bit", d1, 1'b1);
            end
            if (i == 8) begin
                chk("seed_lane2_state", u_dut.lfsr_q[2], 16'h1234);
                chk("seed_lane2_slice", d4[11:8], 4'h1);
            end
            if (i == 12) chk("ffff_seed_ch0", u_dut.lfsr_q[0], 16'hCAFE);
        end
        seed_valid = 1'b0;

        // Asynchronous reset between edges during a burst.
        en = 1'b1; out_ready = 1'b1;
        repeat (5) cycle();
        #3 rst = 1'b0;
        #1;
        chk("arst_valid", v4, 1'b0);
        chk("arst_cnt", wc4, 0);
        chk("arst_lock", lock4, 1'b0);
        for (int c = 0; c < 4; c++) chk($sformatf("arst_lane%0d", c), u_dut.lfsr_q[c], m_dseed(c));
        model_reset();
        en = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_all();

        // Lock-up recovery on a channel forced into the all-ones state.
        for (int c = 0; c < 4; c++) fv[c] = lane_state(c);
        fv[1] = 16'hFFFF;
        force u_dut.lfsr_q = fv;
        #1 release u_dut.lfsr_q;
        lane_load(1, 16'hFFFF);
        cycle();
        chk("lockup_reload", u_dut.lfsr_q[1], 16'h54C9);
        chk("lockup_flag", lock4, 1'b1);
        repeat (2) cycle();

        // Counter wrap from the all-ones value.
        fcnt = '1;
        force u_dut.word_cnt = fcnt;
        #1 release u_dut.word_cnt;
        m_cnt[0] = '1;
        en = 1'b1; out_ready = 1'b1;
        cycle();
        cycle();
        chk("cnt_wrap", wc4, 0);

        // Randomized traffic with occasional reseeds.
        for (int i = 0; i < 400; i++) begin
            en         = ($urandom_range(0, 7) != 0);
            out_ready  = $urandom_range(0, 1) != 0;
            seed_valid = ($urandom_range(0, 9) == 0);
            seed_ch    = 2'($urandom_range(0, 3));
            seed_data  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            sv1        = ($urandom_range(0, 9) == 0);
            sch1       = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lfsr_bank_lookahead.md
Name: lfsr_bank_lookahead

Overview:
- Bank of CH independent Fibonacci XNOR LFSRs. Each LFSR advances N steps per accepted word and emits N pseudorandom bits per channel.
- Output is a valid/ready stream, so RBM sampling units can stall the generator without losing sequence position.
- Adds per-channel runtime reseeding, lock-up detection with auto-recovery, and a generated-word counter for test and debug.

Parameters:
- LENGTH, 16: LFSR state width per channel.
- N, 4: bits produced per channel per accepted word; legal range 1 ≤ N < LENGTH.
- CH, 4: number of channels; legal range ≥ 1.
- TAPS, 16'b1011010000000000: LENGTH-bit tap mask, MSB-aligned, shared by all channels.
- SEED, 16'hcafe: LENGTH-bit base seed.
- CW, 32: width of the word counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  generator enable.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  CH*N  channel c occupies bits [c*N +: N].
- seed_valid  in  1  load-seed strobe.
- seed_ch  in  max(1,$clog2(CH))  target channel.
- seed_data  in  LENGTH  seed value.
- lock_err  out  1  sticky lock-up flag.
- word_cnt  out  CW  count of accepted words.

Behaviour:
- Default seed for channel c: DSEED[c] = SEED ^ (c * 16'h9E37), truncated or zero-extended to LENGTH. If the result is all-ones, DSEED[c] = SEED. All-ones is the XNOR lock-up state.
- Single-step rule for state s:
  - b = ~^(s & TAPS)
  - s' = {s[LENGTH-2:0], b}
- N-step lookahead is defined as exactly N single steps, computed combinationally in one cycle. The first generated bit lands at state bit N-1; the last lands at bit 0.
- out_data slice for channel c = s_c[LENGTH-1 -: N], i.e. the MSBs of the current state. Combinational from state; no extra latency.
- Reset (rst=0, asynchronous):
  - s_c = DSEED[c]
  - out_valid = 0, lock_err = 0, word_cnt = 0
  - FSM = IDLE
- FSM states:
  - IDLE: out_valid=0. Go to RUN when en=1.
  - RUN: out_valid=1. Go to IDLE when en=0.
  - en is sampled on the clock edge, so out_valid rises the cycle after en rises.
- Handshake:
  - Accept = out_valid & out_ready.
  - On accept, every channel advances N steps and word_cnt increments, wrapping modulo 2^CW.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - Deasserting en while out_valid=1 and out_ready=0 is legal: the word is dropped, with no advance.
- Seed load (seed_valid=1, seed_ch < CH):
  - Next cycle, s[seed_ch] = seed_data. This overrides any advance on that same channel that cycle; other channels advance normally.
  - If seed_data is all-ones, load DSEED[seed_ch] instead and set lock_err.
  - seed_ch ≥ CH: ignored, no state change.
  - A seed load is accepted in any FSM state.
- Lock-up detection:
  - Any channel state equal to all-ones at a clock edge, with no seed load to that channel, triggers recovery.
  - Recovery: the channel is reloaded with DSEED[c] on that edge instead of advancing, and lock_err is set.
  - A word accepted in the same cycle is still counted.
  - lock_err is cleared only by reset.
- Simultaneous accept and seed load to channel k: channel k takes the seed; other channels advance; word_cnt increments.
- Reset mid-stream takes effect immediately and asynchronously. No partial update survives.

Test Plan:
- Reset release, CH=1, N=1, defaults, en=0 → out_valid=0, out_data=1'b1 (MSB of 0xcafe), word_cnt=0. Raise en → out_valid=1 on the next edge.
- CH=1, N=1, out_ready=1 for one accept → state 0x95FC, out_data=1, word_cnt=1. Run 64 accepts → bitstream matches a software single-step XNOR model.
- N=4, CH=4 → each lane's nibble sequence over 100 accepts equals 4 concatenated single-step model bits from that lane's DSEED. Hold out_ready=0 for 5 cycles → out_data and word_cnt unchanged.
- seed_valid with seed_ch=2, seed_data=16'h1234, concurrent with an accept → lane 2 state=0x1234 and its out_data slice=4'h1; lanes 0, 1, 3 advanced; word_cnt+1.
- seed_data=16'hFFFF to ch 0 → ch 0 loads DSEED[0]=0xcafe and lock_err=1. Force ch 1 state to all-ones via hierarchy → reloaded with DSEED[1] next edge; lock_err stays 1 until rst=0.
- Assert rst=0 mid-burst, asynchronously between edges → out_valid, word_cnt and lock_err drop immediately, and states return to DSEED. Preload word_cnt to 2^CW-1 and accept → wraps to 0.
